// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store initiator between the CPU execute stage and a byte-addressed
// data memory. Accepts one request at a time, drives the memory bus from
// registers, splits misaligned halfwords into two byte accesses (big-endian),
// extends byte loads and flags out-of-range addresses.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid / req_ready    request handshake (ready only in IDLE)
//   req_we, req_size         store/load, byte/halfword
//   req_signed               sign-extend byte loads
//   req_addr, req_wdata      byte address, store data
//   resp_valid               one-cycle completion pulse
//   resp_rdata, resp_err     load result, range error
//   mem_rw, mem_addr         memory write enable, byte address
//   mem_wdata, mem_memc      memory write data, size (0 = byte, 1 = halfword)
//   mem_rdata                memory read data (combinational from mem_addr)
module mem_access_unit #(
   parameter int unsigned MEM_BYTES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic        req_size,
   input  logic        req_signed,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_wdata,
   output logic        resp_valid,
   output logic [15:0] resp_rdata,
   output logic        resp_err,
   output logic        mem_rw,
   output logic [15:0] mem_addr,
   output logic [15:0] mem_wdata,
   output logic        mem_memc,
   input  logic [15:0] mem_rdata
);

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned BW = 8;
   // One extra bit so addr+1 cannot wrap when checking the range
   localparam logic [AW:0] ADDR_LIMIT = (AW+1)'(MEM_BYTES);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC1 = 2'd1,
      ACC2 = 2'd2,
      RESP = 2'd3
   } state_t;

   state_t state_q, state_d;

   // Latched request
   logic          we_q;
   logic          size_q;
   logic          sgn_q;
   logic          split_q;
   logic [AW-1:0] addr_q;
   logic [BW-1:0] wdata_lo_q;

   // High result byte of a split load, captured in ACC1
   logic [BW-1:0] hi_q, hi_d;

   // Next values of the registered outputs
   logic          req_ready_d;
   logic          resp_valid_d;
   logic          resp_err_d;
   logic [DW-1:0] resp_rdata_d;
   logic          mem_rw_d;
   logic [AW-1:0] mem_addr_d;
   logic [DW-1:0] mem_wdata_d;
   logic          mem_memc_d;

   // Request classification, used only while IDLE
   logic accept_c;
   logic range_err_c;
   logic split_c;

   always_comb begin
      accept_c    = (state_q == IDLE) && req_valid;
      range_err_c = ({1'b0, req_addr} >= ADDR_LIMIT) ||
                    (req_size && (({1'b0, req_addr} + (AW+1)'(1)) >= ADDR_LIMIT));
      split_c     = req_size && req_addr[0];
   end

   // Next-state and next-output logic
   always_comb begin
      state_d      = state_q;
      hi_d         = hi_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      mem_rw_d     = 1'b0;
      mem_addr_d   = '0;
      mem_wdata_d  = '0;
      mem_memc_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (req_valid) begin
               if (range_err_c) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else begin
                  // First access is driven from the incoming request
                  state_d    = ACC1;
                  mem_rw_d   = req_we;
                  mem_addr_d = req_addr;
                  mem_memc_d = req_size && !req_addr[0];
                  if (!req_size)
                     mem_wdata_d = {8'h00, req_wdata[7:0]};
                  else if (split_c)
                     mem_wdata_d = {8'h00, req_wdata[15:8]};
                  else
                     mem_wdata_d = req_wdata;
               end
            end
         end

         ACC1: begin
            if (split_q) begin
               state_d     = ACC2;
               hi_d        = mem_rdata[7:0];
               mem_rw_d    = we_q;
               mem_addr_d  = AW'(addr_q + AW'(1));
               mem_wdata_d = {8'h00, wdata_lo_q};
            end else begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               if (!we_q) begin
                  if (size_q)
                     resp_rdata_d = mem_rdata;
                  else
                     resp_rdata_d = {{BW{mem_rdata[7] & sgn_q}}, mem_rdata[7:0]};
               end
            end
         end

         ACC2: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            if (!we_q)
               resp_rdata_d = {hi_q, mem_rdata[7:0]};
         end

         RESP: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      req_ready_d = (state_d == IDLE);
   end

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         hi_q       <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= '0;
         mem_rw     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_memc   <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         req_ready  <= req_ready_d;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         resp_rdata <= resp_rdata_d;
         mem_rw     <= mem_rw_d;
         mem_addr   <= mem_addr_d;
         mem_wdata  <= mem_wdata_d;
         mem_memc   <= mem_memc_d;
      end
   end

   // Request latch, loaded on acceptance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         we_q       <= 1'b0;
         size_q     <= 1'b0;
         sgn_q      <= 1'b0;
         split_q    <= 1'b0;
         addr_q     <= '0;
         wdata_lo_q <= '0;
      end else if (accept_c) begin
         we_q       <= req_we;
         size_q     <= req_size;
         sgn_q      <= req_signed;
         split_q    <= split_c;
         addr_q     <= req_addr;
         wdata_lo_q <= req_wdata[7:0];
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a byte-array memory model drives
// mem_rdata and absorbs writes; a transaction-level reference memory predicts
// every response, latency and write count.
module tb_mem_access_unit;

   localparam int unsigned MEM_BYTES = 64;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_size;
   logic        req_signed;
   logic [15:0] req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic [15:0] resp_rdata;
   logic        resp_err;
   logic        mem_rw;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_memc;
   logic [15:0] mem_rdata;

   int checks   = 0;
   int failures = 0;

   mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_rw     (mem_rw),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_memc   (mem_memc),
      .mem_rdata  (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory seen by the DUT
   logic [7:0] bmem [MEM_BYTES];
   // Reference memory updated from request semantics only
   logic [7:0] ref_mem [MEM_BYTES];

   logic [15:0] wr_addr_q [$];
   logic [15:0] wr_data_q [$];
   logic        wr_memc_q [$];

   always_comb begin
      if (mem_memc)
         mem_rdata = {bmem[mem_addr[5:0]], bmem[6'(mem_addr[5:0] + 6'd1)]};
      else
         mem_rdata = {8'h00, bmem[mem_addr[5:0]]};
   end

   always @(posedge clk) begin
      if (!rst && mem_rw) begin
         if (mem_memc) begin
            bmem[mem_addr[5:0]]                 = mem_wdata[15:8];
            bmem[6'(mem_addr[5:0] + 6'd1)]      = mem_wdata[7:0];
         end else begin
            bmem[mem_addr[5:0]]                 = mem_wdata[7:0];
         end
         wr_addr_q.push_back(mem_addr);
         wr_data_q.push_back(mem_wdata);
         wr_memc_q.push_back(mem_memc);
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int mem_diffs();
      int n = 0;
      for (int i = 0; i < int'(MEM_BYTES); i++)
         if (bmem[i] !== ref_mem[i]) n++;
      return n;
   endfunction

   task automatic clear_writes();
      wr_addr_q.delete();
      wr_data_q.delete();
      wr_memc_q.delete();
   endtask

   // One complete transaction, predicted from the reference memory
   task automatic do_req(input logic we, input logic size, input logic sgn,
                         input logic [15:0] addr, input logic [15:0] wdata,
                         input string tag, output logic [15:0] rdata_o);
      int          a;
      logic        err_e;
      logic [15:0] rd_e;
      int          lat_e;
      int          nwr_e;
      int          lat;
      int          n;
      logic        err_g;
      logic [15:0] rd_g;

      a     = int'(addr);
      err_e = (a >= int'(MEM_BYTES)) || (size && (a + 1 >= int'(MEM_BYTES)));
      rd_e  = 16'h0000;
      nwr_e = 0;
      if (err_e) begin
         lat_e = 1;
      end else begin
         lat_e = (size && addr[0]) ? 3 : 2;
         if (we) begin
            nwr_e = (size && addr[0]) ? 2 : 1;
            if (size) begin
               ref_mem[a]     = wdata[15:8];
               ref_mem[a + 1] = wdata[7:0];
            end else begin
               ref_mem[a]     = wdata[7:0];
            end
         end else if (size) begin
            rd_e = {ref_mem[a], ref_mem[a + 1]};
         end else begin
            rd_e = {(sgn && ref_mem[a][7]) ? 8'hFF : 8'h00, ref_mem[a]};
         end
      end

      @(negedge clk);
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check_eq({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);

      clear_writes();
      req_we     = we;
      req_size   = size;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;

      lat   = 0;
      err_g = 1'b0;
      rd_g  = 16'hxxxx;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat   = k;
            err_g = resp_err;
            rd_g  = resp_rdata;
            break;
         end
      end
      rdata_o = rd_g;
      check_eq({tag, "_latency"}, 64'(lat), 64'(lat_e));
      check_eq({tag, "_err"}, 64'(err_g), 64'(err_e));
      check_eq({tag, "_rdata"}, 64'(rd_g), 64'(rd_e));
      check_eq({tag, "_nwrites"}, 64'(wr_addr_q.size()), 64'(nwr_e));
      @(negedge clk);
      check_eq({tag, "_pulse_ready"}, {62'd0, resp_valid, req_ready}, 64'b01);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_eq(tag, {req_ready, resp_valid, resp_err, resp_rdata, mem_rw, mem_addr, mem_wdata, mem_memc},
               {1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0});
   endtask

   logic [15:0] rd;
   int          acc_cyc  [4];
   int          resp_cyc [4];
   logic [15:0] resp_dat [4];
   logic        rdy      [24];
   int          na, nr, nlow;
   logic [15:0] b2b_addr [3];

   initial begin
      for (int i = 0; i < int'(MEM_BYTES); i++) begin
         bmem[i]    = 8'h00;
         ref_mem[i] = 8'h00;
      end
      rst        = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_size   = 1'b0;
      req_signed = 1'b0;
      req_addr   = 16'h0;
      req_wdata  = 16'h0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      rst = 1'b0;

      // Aligned halfword round trip
      do_req(1'b1, 1'b1, 1'b0, 16'd4, 16'hA55A, "st_al", rd);
      check_eq("st_al_bus", {wr_addr_q[0], wr_data_q[0], 15'd0, wr_memc_q[0]},
               {16'd4, 16'hA55A, 16'd1});
      do_req(1'b0, 1'b1, 1'b0, 16'd4, 16'h0, "ld_al", rd);
      check_eq("ld_al_value", 64'(rd), 64'hA55A);

      // Split halfword round trip
      do_req(1'b1, 1'b1, 1'b0, 16'd7, 16'h1234, "st_sp", rd);
      check_eq("st_sp_bus", {wr_addr_q[0], wr_data_q[0], wr_addr_q[1], wr_data_q[1]},
               {16'd7, 16'h0012, 16'd8, 16'h0034});
      do_req(1'b0, 1'b1, 1'b0, 16'd7, 16'h0, "ld_sp", rd);
      check_eq("ld_sp_value", 64'(rd), 64'h1234);

      // Byte load extension
      do_req(1'b1, 1'b0, 1'b0, 16'd10, 16'h5580, "st_b", rd);
      do_req(1'b0, 1'b0, 1'b1, 16'd10, 16'h0, "ld_bs", rd);
      check_eq("ld_bs_value", 64'(rd), 64'hFF80);
      do_req(1'b0, 1'b0, 1'b0, 16'd10, 16'h0, "ld_bu", rd);
      check_eq("ld_bu_value", 64'(rd), 64'h0080);

      // Range errors
      do_req(1'b0, 1'b0, 1'b0, 16'd64, 16'h0, "err_ld64", rd);
      do_req(1'b1, 1'b1, 1'b0, 16'd63, 16'hDEAD, "err_st63", rd);
      do_req(1'b1, 1'b0, 1'b0, 16'd63, 16'h00C3, "edge_st63b", rd);
      check_eq("mem_after_errors", 64'(mem_diffs()), 64'd0);

      // Reset in the middle of a split store
      @(negedge clk);
      clear_writes();
      req_we = 1'b1; req_size = 1'b1; req_signed = 1'b0;
      req_addr = 16'd21; req_wdata = 16'hBEEF; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check_reset_outputs("rst_mid_outputs");
      @(negedge clk);
      check_eq("rst_mid_no_resp", 64'(resp_valid), 64'd0);
      rst = 1'b0;
      ref_mem[21] = 8'hBE;
      check_eq("rst_mid_writes", {48'(wr_addr_q.size()), wr_addr_q[0]}, {48'd1, 16'd21});
      do_req(1'b0, 1'b0, 1'b0, 16'd21, 16'h0, "rst_mid_ld", rd);
      check_eq("rst_mid_value", 64'(rd), 64'h00BE);
      check_eq("rst_mid_ld22", 64'(bmem[22]), 64'h00);

      // Back-to-back aligned byte loads with req_valid held
      b2b_addr[0] = 16'd4; b2b_addr[1] = 16'd10; b2b_addr[2] = 16'd8;
      @(negedge clk);
      req_we = 1'b0; req_size = 1'b0; req_signed = 1'b1;
      req_addr = b2b_addr[0]; req_valid = 1'b1;
      na = 0; nr = 0;
      for (int i = 0; i < 24; i++) begin
         if (i > 0) @(negedge clk);
         rdy[i] = req_ready;
         if (resp_valid && nr < 4) begin
            resp_cyc[nr] = i;
            resp_dat[nr] = resp_rdata;
            nr++;
         end
         if (req_valid && req_ready && na < 3) begin
            acc_cyc[na] = i;
            na++;
            @(posedge clk);
            #1;
            if (na == 3) req_valid = 1'b0;
            else         req_addr  = b2b_addr[na];
         end
      end
      check_eq("b2b_accepts", 64'(na), 64'd3);
      check_eq("b2b_resps", 64'(nr), 64'd3);
      if (na == 3 && nr == 3) begin
         check_eq("b2b_acc_gap", {32'(acc_cyc[1] - acc_cyc[0]), 32'(acc_cyc[2] - acc_cyc[1])},
                  {32'd3, 32'd3});
         check_eq("b2b_resp_gap", {32'(resp_cyc[1] - resp_cyc[0]), 32'(resp_cyc[2] - resp_cyc[1])},
                  {32'd3, 32'd3});
         nlow = 0;
         for (int i = acc_cyc[0] + 1; i < acc_cyc[1]; i++)
            if (!rdy[i]) nlow++;
         check_eq("b2b_ready_low", 64'(nlow), 64'd2);
         for (int j = 0; j < 3; j++)
            check_eq("b2b_rdata", 64'(resp_dat[j]),
                     64'({ref_mem[b2b_addr[j]][7] ? 8'hFF : 8'h00, ref_mem[b2b_addr[j]]}));
      end

      // Randomized traffic against the reference memory
      for (int t = 0; t < 150; t++) begin
         logic [15:0] ra;
         ra = ($urandom_range(0, 15) == 0) ? 16'($urandom) : 16'($urandom_range(0, 70));
         do_req(1'($urandom), 1'($urandom), 1'($urandom), ra, 16'($urandom), "rnd", rd);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      check_eq("mem_final", 64'(mem_diffs()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store initiator that sits between the CPU execute stage and the byte-addressed data memory. It accepts one load or store request at a time over a valid/ready handshake and drives the memory's read/write, address, write-data and size (memc) inputs. It captures returned data, sign- or zero-extends byte loads, and splits misaligned halfword accesses into two byte accesses. It also flags out-of-range addresses and returns a single-cycle response to the CPU.

## Interface
- MEM_BYTES, 64, size of the data memory in bytes; valid addresses are 0..MEM_BYTES-1
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  CPU presents a request
- req_ready  out  1  unit can accept a request; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_size  in  1  0 = byte, 1 = halfword
- req_signed  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend
- req_addr  in  16  byte address
- req_wdata  in  16  store data; byte stores use [7:0]
- resp_valid  out  1  one-cycle pulse; the request is complete
- resp_rdata  out  16  load result; 0 for stores and errors
- resp_err  out  1  qualifies resp_valid; address out of range
- mem_rw  out  1  memory write enable: 1 = write, 0 = read
- mem_addr  out  16  memory byte address
- mem_wdata  out  16  memory write data
- mem_memc  out  1  memory size: 0 = 1 byte, 1 = 2 bytes
- mem_rdata  in  16  memory read data, combinational from mem_addr

## Operation
- **Byte order.** Big-endian halfwords: the high byte is at the even address and the low byte at the next address.
- **FSM states:** IDLE, ACC1, ACC2, RESP.
- **IDLE**
  - req_ready=1.
  - When req_valid=1, latch the request and classify it:
    - Error: addr >= MEM_BYTES, or a halfword with addr+1 >= MEM_BYTES. Go to RESP with err=1; the memory is not touched.
    - Aligned: a byte access, or a halfword with addr[0]=0. Go to ACC1 and issue one access.
    - Split: a halfword with addr[0]=1. Go to ACC1 and issue two byte accesses.
- **ACC1**
  - Bus values:
    - mem_addr = latched addr.
    - mem_memc = 1 for an aligned halfword, else 0.
    - mem_rw = req_we.
    - mem_wdata = wdata for an aligned halfword; {8'h00, wdata[15:8]} for a split; {8'h00, wdata[7:0]} for a byte.
  - Loads capture mem_rdata at the end of the cycle.
  - Next state: ACC2 if split, else RESP.
- **ACC2** (split only)
  - Bus values: mem_addr = addr+1, mem_memc=0, mem_wdata = {8'h00, wdata[7:0]}, mem_rw = req_we.
  - Loads capture mem_rdata[7:0] as the low result byte.
  - Next state: RESP.
- **RESP**
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - There is no response backpressure.
- **Load result**
  - Aligned halfword: mem_rdata[15:0].
  - Split halfword: {ACC1 byte, ACC2 byte}.
  - Byte: {8{b[7]} & req_signed, b}, where b = mem_rdata[7:0].
  - req_signed is ignored for halfwords.
- **Idle bus.** Outside ACC1/ACC2: mem_rw=0, mem_memc=0, mem_addr=0, mem_wdata=0. No write is ever issued outside ACC1/ACC2.
- **Registered outputs.** All mem_* outputs and resp_* outputs come from registers, so the bus carries no combinational path from req_*.

## Timing
- **Reset values:** req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_rw=0, mem_addr=0, mem_wdata=0, mem_memc=0. State is IDLE.
- **Latency.** Request accepted at edge N:
  - Aligned access: bus active in cycle N+1, resp_valid in cycle N+2.
  - Split access: bus active in cycles N+1 and N+2, resp_valid in cycle N+3.
  - Error: resp_valid in cycle N+1.
- **Ready.** req_ready falls the cycle after acceptance and returns to 1 in the cycle after the RESP cycle. A request presented during RESP is not accepted.
- **Write strobe.** mem_rw=1 lasts exactly one cycle per access, and mem_addr and mem_wdata are stable for that entire cycle.
- **Reset mid-operation.** The unit returns to IDLE immediately and resp_valid stays 0. A split store interrupted after ACC1 leaves only the high byte written.
- **Back-to-back requests.** req_valid held high produces one accepted request every 3 cycles (aligned) or 4 cycles (split).

## Test plan
- **Aligned halfword round trip.** Store halfword 16'hA55A to addr 4; load from 4.
  - Store bus: mem_rw=1, memc=1, addr=4 for one cycle.
  - Load returns resp_rdata=16'hA55A two cycles after acceptance.
- **Split halfword round trip.** Store halfword 16'h1234 to addr 7; load halfword from 7.
  - Store bus: two byte writes, addr 7 with 8'h12, then addr 8 with 8'h34.
  - Load returns 16'h1234, resp_valid three cycles after acceptance.
- **Byte load extension.** Store byte 8'h80 to addr 10.
  - Signed byte load from 10 returns 16'hFF80.
  - Unsigned byte load from 10 returns 16'h0080.
- **Range errors.** Each of the following gives resp_err=1 and resp_rdata=0 one cycle after acceptance, with mem_rw never 1 and memory contents unchanged:
  - Load from addr 64.
  - Halfword store to addr 63.
- **Reset mid-split.** Split store 16'hBEEF at addr 21; assert rst during ACC2.
  - Outputs return to reset values immediately.
  - A later byte load from 21 returns 16'h00BE.
- **Back-to-back throughput.** Hold req_valid=1 for three aligned byte loads.
  - resp_valid pulses exactly 3 cycles apart.
  - req_ready low for 2 cycles between acceptances.
